// File: rtl/vnlp_pkg.sv
// Shared types and constants for the vector-norm linked-list walker control.
package vnlp_pkg;

  localparam int ADDR_W = 9;
  localparam int LEN_W  = 7;
  localparam int TMR_W  = 3;
  localparam logic [ADDR_W-1:0] HEAD_ADDR = 9'd0;
  localparam int X_OFS  = 2;
  localparam int Y_OFS  = 3;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CLEAR,
    S_PTR_SETUP,
    S_PTR_LOAD,
    S_CHECK,
    S_XY_SETUP,
    S_XY_LOAD,
    S_FLUSH1,
    S_FLUSH2,
    S_DONE
  } vnlp_state_t;

  typedef struct packed {
    logic load_add_r;
    logic load_i_r;
    logic sel_a1;
    logic inc_len;
    logic dp_clr_n;
    logic busy;
    logic done;
  } vnlp_ctl_t;

  localparam vnlp_ctl_t CTL_RESET = '{
    load_add_r: 1'b0, load_i_r: 1'b0, sel_a1: 1'b0, inc_len: 1'b0,
    dp_clr_n: 1'b1, busy: 1'b0, done: 1'b0
  };

endpackage

// File: rtl/vnlp_wait_timer.sv
// Small down-counter that stretches the address-settle states by RD_WAIT cycles.
module vnlp_wait_timer
  import vnlp_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [TMR_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [TMR_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                       cnt_q <= '0;
    else if (load_i)                cnt_q <= load_val_i;
    else if (dec_i && cnt_q != '0)  cnt_q <= cnt_q - 1'b1;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/vnlp_control_unit.sv
// Sequencer for the linked-list norm datapath: pointer loads, operand loads, flush, done.
// All outputs are flops decoded from next state, since load_add_r is used as a clock downstream.
module vnlp_control_unit
  import vnlp_pkg::*;
#(
  parameter int unsigned RD_WAIT = 0,
  parameter int unsigned MAX_LEN = 127
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             done_i,
  input  logic [LEN_W-1:0] len,
  output logic             load_add_r,
  output logic             load_i_r,
  output logic             sel_a1,
  output logic             inc_len,
  output logic             dp_clr_n,
  output logic             busy,
  output logic             done,
  output logic             err_overflow
);

  localparam logic [TMR_W-1:0] PTR_WAIT  = TMR_W'(RD_WAIT);
  localparam logic [TMR_W-1:0] XY_WAIT   = (RD_WAIT == 0) ? '0 : TMR_W'(RD_WAIT - 1);
  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

  vnlp_state_t      state_q, state_d;
  vnlp_ctl_t        ctl_q, ctl_d;
  logic             err_q, err_d;
  logic             tmr_load, tmr_dec, tmr_zero, ovf_set;
  logic [TMR_W-1:0] tmr_val;

  vnlp_wait_timer u_timer (
    .clk       (clk),
    .rst       (rst),
    .load_i    (tmr_load),
    .load_val_i(tmr_val),
    .dec_i     (tmr_dec),
    .zero_o    (tmr_zero)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      ctl_q   <= CTL_RESET;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ctl_q   <= ctl_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    tmr_dec  = 1'b0;
    ovf_set  = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: if (start) state_d = S_CLEAR;
      S_CLEAR: begin
        state_d  = S_PTR_SETUP;
        tmr_load = 1'b1;
        tmr_val  = PTR_WAIT;
      end
      S_PTR_SETUP: begin
        if (tmr_zero) state_d = S_PTR_LOAD;
        else          tmr_dec = 1'b1;
      end
      S_PTR_LOAD: state_d = S_CHECK;
      // End-of-list wins over overflow when both could apply.
      S_CHECK: begin
        if (done_i) begin
          state_d = S_FLUSH1;
        end else if (len == MAX_LEN_L) begin
          state_d = S_FLUSH1;
          ovf_set = 1'b1;
        end else if (RD_WAIT == 0) begin
          state_d = S_XY_LOAD;
        end else begin
          state_d  = S_XY_SETUP;
          tmr_load = 1'b1;
          tmr_val  = XY_WAIT;
        end
      end
      S_XY_SETUP: begin
        if (tmr_zero) state_d = S_XY_LOAD;
        else          tmr_dec = 1'b1;
      end
      S_XY_LOAD: begin
        state_d  = S_PTR_SETUP;
        tmr_load = 1'b1;
        tmr_val  = PTR_WAIT;
      end
      S_FLUSH1: state_d = S_FLUSH2;
      S_FLUSH2: state_d = S_DONE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ctl_d      = CTL_RESET;
    ctl_d.busy = !(state_d == S_IDLE || state_d == S_DONE);
    case (state_d)
      S_CLEAR:    ctl_d.dp_clr_n   = 1'b0;
      S_PTR_LOAD: ctl_d.load_add_r = 1'b1;
      S_XY_SETUP: ctl_d.sel_a1     = 1'b1;
      S_XY_LOAD: begin
        ctl_d.sel_a1   = 1'b1;
        ctl_d.load_i_r = 1'b1;
        ctl_d.inc_len  = 1'b1;
      end
      S_FLUSH1, S_FLUSH2: begin
        ctl_d.sel_a1   = 1'b1;
        ctl_d.load_i_r = 1'b1;
      end
      S_DONE:     ctl_d.done       = 1'b1;
      default:    ;
    endcase
    err_d = err_q;
    if (ovf_set)                 err_d = 1'b1;
    else if (state_d == S_CLEAR) err_d = 1'b0;
  end

  assign load_add_r   = ctl_q.load_add_r;
  assign load_i_r     = ctl_q.load_i_r;
  assign sel_a1       = ctl_q.sel_a1;
  assign inc_len      = ctl_q.inc_len;
  assign dp_clr_n     = ctl_q.dp_clr_n;
  assign busy         = ctl_q.busy;
  assign done         = ctl_q.done;
  assign err_overflow = err_q;

endmodule

// File: tb/tb_vnlp_control_unit.sv
// Randomized list walks against a list-walking reference model, with a behavioural datapath.
module tb_vnlp_control_unit;
  localparam int W  = 2;
  localparam int ML = 4;

  logic clk = 1'b0, rst = 1'b0, start = 1'b0;
  logic done_i;
  logic [6:0] len;
  logic load_add_r, load_i_r, sel_a1, inc_len, dp_clr_n, busy, done, err_overflow;

  always #5 clk = ~clk;

  vnlp_control_unit #(.RD_WAIT(W), .MAX_LEN(ML)) dut (
    .clk(clk), .rst(rst), .start(start), .done_i(done_i), .len(len),
    .load_add_r(load_add_r), .load_i_r(load_i_r), .sel_a1(sel_a1), .inc_len(inc_len),
    .dp_clr_n(dp_clr_n), .busy(busy), .done(done), .err_overflow(err_overflow)
  );

  // Behavioural datapath: base register, link counter, 3-deep square/accumulate pipe.
  logic [23:0] mem [512];
  logic        dp_rst_n;
  logic [8:0]  base_q, a1;
  longint      r0, r1, r2, r3, acc;

  assign dp_rst_n = rst & dp_clr_n;
  assign a1 = sel_a1 ? base_q + 9'd2 : base_q;

  always @(posedge clk or negedge dp_rst_n) begin
    if (!dp_rst_n) begin
      base_q <= '0; done_i <= 1'b0; len <= '0;
      r0 <= 0; r1 <= 0; r2 <= 0; r3 <= 0; acc <= 0;
    end else begin
      if (load_add_r) begin
        base_q <= mem[base_q][8:0];
        done_i <= (mem[base_q][8:0] == 9'd0);
      end
      if (inc_len) len <= len + 7'd1;
      if (load_i_r) begin
        r0  <= longint'(mem[a1]);
        r1  <= longint'(mem[a1 + 9'd1]);
        r2  <= r0 * r0;
        r3  <= r1 * r1;
        acc <= acc + r2 + r3;
      end
    end
  end

  typedef struct {
    int     t0;
    int     cyc;
    int     n;
    longint sum;
    bit     err;
    int     adds;
    int     lds;
  } exp_t;

  exp_t sb[$];
  int   errors = 0, checks = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: follow pointers from mem[0], stopping at a null pointer or MAX_LEN nodes.
  function automatic exp_t model(input int t0);
    exp_t e;
    int   p;
    longint x, y;
    e.t0 = t0; e.n = 0; e.sum = 0; e.err = 1'b0; e.adds = 1;
    p = int'(mem[0][8:0]);
    while (p != 0) begin
      if (e.n == ML) begin
        e.err = 1'b1;
        break;
      end
      x = longint'(mem[p + 2]);
      y = longint'(mem[p + 3]);
      e.sum += x * x + y * y;
      e.n++;
      e.adds++;
      p = int'(mem[p][8:0]);
    end
    e.cyc = 6 + W + e.n * (4 + 2 * W);
    e.lds = e.n + 2;
    return e;
  endfunction

  // Monitor: pulse counting, per-load invariants, scoreboard pop on DONE entry.
  initial begin
    int   cnt_add = 0, cnt_ld = 0;
    logic done_prev = 1'b0, sel_prev = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst || !dp_clr_n) begin
        cnt_add = 0; cnt_ld = 0;
      end
      if (load_add_r) begin
        cnt_add++;
        chk("sel_a1_on_ptr_load", sel_a1, 0);
        chk("sel_a1_before_ptr_load", sel_prev, 0);
        chk("load_overlap", load_i_r, 0);
      end
      if (load_i_r) cnt_ld++;
      if (done && !done_prev) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got done=1, want no completion (t=%0t)", $time);
        end else begin
          e = sb.pop_front();
          chk("done_edge", cyc - e.t0, e.cyc);
          chk("len", len, e.n);
          chk("norm2", acc, e.sum);
          chk("err_overflow", err_overflow, e.err);
          chk("load_add_pulses", cnt_add, e.adds);
          chk("load_i_pulses", cnt_ld, e.lds);
          chk("busy_in_done", busy, 0);
        end
      end
      done_prev = done;
      sel_prev  = sel_a1;
    end
  end

  task automatic fill_mem();
    for (int i = 0; i < 512; i++) mem[i] = 24'($urandom);
  endtask

  task automatic build_list(input int nodes[$]);
    mem[0][8:0] = (nodes.size() > 0) ? 9'(nodes[0]) : 9'd0;
    for (int i = 0; i < nodes.size(); i++)
      mem[nodes[i]][8:0] = (i + 1 < nodes.size()) ? 9'(nodes[i + 1]) : 9'd0;
  endtask

  task automatic rand_list(input int n);
    int nodes[$];
    int k;
    bit dup;
    while (nodes.size() < n) begin
      k = 4 * $urandom_range(1, 127);
      dup = 1'b0;
      foreach (nodes[j]) if (nodes[j] == k) dup = 1'b1;
      if (!dup) nodes.push_back(k);
    end
    fill_mem();
    build_list(nodes);
  endtask

  task automatic launch();
    @(negedge clk);
    start = 1'b1;
    sb.push_back(model(cyc + 1));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || sb.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      checks++; errors++;
      $display("FAIL walk_timeout: got busy=%0b pending=%0d, want idle", busy, sb.size());
      sb.delete();
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_load_add_r"}, load_add_r, 0);
    chk({tag, "_load_i_r"}, load_i_r, 0);
    chk({tag, "_sel_a1"}, sel_a1, 0);
    chk({tag, "_inc_len"}, inc_len, 0);
    chk({tag, "_dp_clr_n"}, dp_clr_n, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err_overflow, 0);
  endtask

  initial begin
    int q[$];
    int k, n;
    fill_mem();
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b1;

    // Empty list still flushes.
    fill_mem(); mem[0][8:0] = 9'd0;
    launch(); wait_idle();

    // Single node at 8.
    fill_mem(); q = '{8}; build_list(q);
    launch(); wait_idle();

    // Random lists up to exactly MAX_LEN nodes (no overflow).
    for (int it = 0; it < 8; it++) begin
      rand_list((it % ML) + 1);
      launch(); wait_idle();
    end

    // One node too many -> overflow abort.
    rand_list(ML + 1);
    launch(); wait_idle();

    // Cyclic list 8 -> 8.
    fill_mem(); mem[0][8:0] = 9'd8; mem[8][8:0] = 9'd8;
    launch(); wait_idle();

    // Start held high in DONE: clear pulse, done/err drop, walk repeats back to back.
    @(negedge clk);
    start = 1'b1;
    sb.push_back(model(cyc + 1));
    @(negedge clk);
    chk("restart_dp_clr_n", dp_clr_n, 0);
    chk("restart_done", done, 0);
    chk("restart_err", err_overflow, 0);
    chk("restart_busy", busy, 1);
    n = 0;
    while (!done && n < 500) begin @(negedge clk); n++; end
    if (!done) begin
      checks++; errors++;
      $display("FAIL held_start_timeout: got done=0, want 1");
    end else begin
      sb.push_back(model(cyc + 1));
      @(negedge clk);
      chk("rerestart_dp_clr_n", dp_clr_n, 0);
      chk("rerestart_done", done, 0);
    end
    start = 1'b0;
    wait_idle();

    // Start pulses while busy are ignored.
    rand_list(3);
    launch();
    repeat (4) @(negedge clk);
    start = 1'b1; @(negedge clk); start = 1'b0;
    chk("busy_after_ignored_start", busy, 1);
    repeat (7) @(negedge clk);
    start = 1'b1; @(negedge clk); start = 1'b0;
    wait_idle();

    // Async reset during the second XY_LOAD, then a clean walk.
    rand_list(3);
    launch();
    k = 0; n = 0;
    while (k < 2 && n < 500) begin
      @(negedge clk);
      if (inc_len) k++;
      n++;
    end
    chk("reached_second_xy_load", k, 2);
    rst = 1'b0;
    #1;
    sb.delete();
    chk_reset_outputs("midwalk_rst");
    @(negedge clk);
    chk_reset_outputs("midwalk_rst_held");
    rst = 1'b1;
    launch(); wait_idle();

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
